core_seq_controller: RTL and testbench
======================================

// Module: core_seq_controller
// PURPOSE
//  Multi-cycle core sequencer: FETCH -> EXEC -> [MEM] -> FETCH with trap entry, interrupt take, WFI sleep,
//  MEM watchdog, retire pulse and cycle/instret counters. Drives stage valids and reg write enable;
//  sits between the fetch/exec/mem stage blocks and the CSR/trap unit of the core.
// PARAMETERS
//  CNT_W        64   width of cycle_count / instret_count (wrap modulo 2^CNT_W)
//  TIMEOUT_W    8    width of MEM watchdog counter
//  MEM_TIMEOUT  200  MEM cycles without mem_stage_ready before timeout trap; 0 = watchdog disabled
// PORTS
//  clk                input   1        clock
//  rst_n              input   1        reset, asynchronous, active-low
//  fetch_stage_valid  output  1        FETCH state active
//  fetch_stage_ready  input   1        fetch done this cycle
//  fetch_fault        input   1        fetch access fault, qualified by fetch handshake
//  exec_stage_valid   output  1        EXEC state active
//  exec_stage_ready   input   1        exec done this cycle
//  mem_op             input   1        current instr is load/store
//  wfi_op             input   1        current instr is WFI
//  exec_exception     input   1        illegal/ecall/ebreak, qualified by exec handshake
//  mem_stage_valid    output  1        MEM state active
//  mem_stage_ready    input   1        mem done this cycle
//  mem_fault          input   1        mem access fault, qualified by mem handshake
//  irq_pending        input   1        enabled, masked interrupt pending (level)
//  reg_d_en           output  1        register file write enable
//  retire             output  1        1-cycle pulse: instruction completed without trap
//  trap_valid         output  1        1-cycle pulse in TRAP state
//  trap_cause         output  3        cause code (core_pkg::cause_e), valid with trap_valid
//  mem_timeout        output  1        sticky: a watchdog trap occurred; cleared by reset only
//  cycle_count        output  CNT_W    free-running cycle counter
//  instret_count      output  CNT_W    retired-instruction counter
// BEHAVIOUR
//  - Reset: state FETCH, counters 0, watchdog 0, mem_timeout 0; all outputs 0 while rst_n low.
//  - States FETCH, EXEC, MEM, TRAP, WFI; exactly one of the *_stage_valid high in its state, 0 elsewhere.
//  - Handshake = valid & ready. Valid held until handshake (except watchdog abort). Zero-wait ready OK.
//  - FETCH: hs & fetch_fault -> TRAP(FETCH_FAULT); hs -> EXEC.
//  - EXEC: hs & exec_exception -> TRAP(EXCEPTION); hs & mem_op -> MEM; hs & wfi_op -> retire, WFI;
//    hs otherwise -> retire, reg_d_en, then TRAP(IRQ) if irq_pending else FETCH.
//  - MEM: hs & mem_fault -> TRAP(MEM_FAULT), no write/retire; hs -> retire, reg_d_en, TRAP(IRQ) if irq_pending else FETCH.
//  - Watchdog: counts MEM cycles without ready, clears on MEM entry; on cycle MEM_TIMEOUT without ready
//    -> TRAP(MEM_TIMEOUT), mem_stage_valid drops, mem_timeout set. Ready on that same cycle wins (normal hs).
//  - WFI: wait; irq_pending -> TRAP(IRQ). WFI instr already retired.
//  - TRAP: exactly 1 cycle, trap_valid=1, then FETCH. Trap unit redirects PC during that cycle.
//  - Priority same cycle: fault/exception > irq. Irq sampled only at retire or in WFI, never mid-stage.
//  - reg_d_en/retire combinational on the completing handshake; never asserted on a trapping hs.
//  - cycle_count +1 every cycle out of reset; instret_count +1 per retire; both wrap all-ones -> 0.
//  - Reset mid-operation: immediate return to reset values, in-flight instr dropped, no retire.
// STRUCTURE
//  - core_pkg: state_e {FETCH,EXEC,MEM,TRAP,WFI}; cause_e {FETCH_FAULT=1,EXCEPTION=2,MEM_FAULT=3,MEM_TIMEOUT=4,IRQ=7}.
//  - Sub-module core_ctrl_counters (CNT_W): cycle + instret counters, input retire.
//  - FSM, watchdog and trap_cause register in top.
// TESTING
//  - ALU instr, ready=1 each state: 2 cycles/instr, reg_d_en+retire on EXEC hs, instret=3 after 3 instrs.
//  - Load, mem_stage_ready after 5 cycles: MEM held 5 cycles, reg_d_en only on MEM hs, retire once.
//  - MEM_TIMEOUT=4, ready never: trap_valid 4 cycles after MEM entry, cause=4, mem_timeout=1, next FETCH.
//  - exec_exception with irq_pending=1 on same hs: cause=2, no reg_d_en, instret unchanged.
//  - WFI retires, irq_pending after 10 cycles: WFI held, then TRAP cause=7, then FETCH.
//  - Preload CNT_W=4, 15 cycles then 1 more: cycle_count wraps 15 -> 0; reset mid-MEM -> FETCH, counts 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types for the core sequencer: FSM state encoding and trap cause codes.
package core_pkg;

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    EXEC  = 3'd1,
    MEM   = 3'd2,
    TRAP  = 3'd3,
    WFI   = 3'd4
  } state_e;

  localparam int CAUSE_W = 3;

  typedef enum logic [CAUSE_W-1:0] {
    CAUSE_NONE        = 3'd0,
    CAUSE_FETCH_FAULT = 3'd1,
    CAUSE_EXCEPTION   = 3'd2,
    CAUSE_MEM_FAULT   = 3'd3,
    CAUSE_MEM_TIMEOUT = 3'd4,
    CAUSE_IRQ         = 3'd7
  } cause_e;

endpackage

// File: rtl/core_ctrl_counters.sv
// Free-running cycle counter and retired-instruction counter; both wrap silently.
module core_ctrl_counters #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             retire,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      cycle_count <= cycle_count + CNT_W'(1);
      if (retire) instret_count <= instret_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/core_seq_controller.sv
// Multi-cycle core sequencer: FETCH -> EXEC -> [MEM] -> FETCH with traps, WFI sleep and MEM watchdog.
//   state | meaning
//   FETCH | fetch stage active, waiting for fetch handshake
//   EXEC  | exec stage active, waiting for exec handshake
//   MEM   | mem stage active, watchdog running
//   TRAP  | one-cycle trap pulse, trap unit redirects PC
//   WFI   | sleeping after a retired WFI until an interrupt is pending
module core_seq_controller
  import core_pkg::*;
#(
  parameter int CNT_W       = 64,
  parameter int TIMEOUT_W   = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             fetch_stage_valid,
  input  logic             fetch_stage_ready,
  input  logic             fetch_fault,
  output logic             exec_stage_valid,
  input  logic             exec_stage_ready,
  input  logic             mem_op,
  input  logic             wfi_op,
  input  logic             exec_exception,
  output logic             mem_stage_valid,
  input  logic             mem_stage_ready,
  input  logic             mem_fault,
  input  logic             irq_pending,
  output logic             reg_d_en,
  output logic             retire,
  output logic             trap_valid,
  output logic [2:0]       trap_cause,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
);

  localparam bit                   WD_EN   = (MEM_TIMEOUT != 0);
  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(MEM_TIMEOUT - 1);

  state_e               state;
  cause_e               cause_q;
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic                 mem_timeout_q;

  logic fetch_hs, exec_hs, mem_hs;
  logic exec_alu_done, exec_wfi_done, mem_done, wd_expire;

  // Stage valids decode the state register; gated by rst_n so everything is quiet in reset.
  assign fetch_stage_valid = rst_n & (state == FETCH);
  assign exec_stage_valid  = rst_n & (state == EXEC);
  assign mem_stage_valid   = rst_n & (state == MEM);
  assign trap_valid        = rst_n & (state == TRAP);
  assign trap_cause        = trap_valid ? 3'(cause_q) : 3'd0;
  assign mem_timeout       = mem_timeout_q;

  assign fetch_hs = fetch_stage_valid & fetch_stage_ready;
  assign exec_hs  = exec_stage_valid & exec_stage_ready;
  assign mem_hs   = mem_stage_valid & mem_stage_ready;

  assign exec_alu_done = exec_hs & ~exec_exception & ~mem_op & ~wfi_op;
  assign exec_wfi_done = exec_hs & ~exec_exception & ~mem_op & wfi_op;
  assign mem_done      = mem_hs & ~mem_fault;

  assign reg_d_en = exec_alu_done | mem_done;
  assign retire   = reg_d_en | exec_wfi_done;

  // A ready arriving on the expiry cycle is a normal handshake, so expiry requires !ready.
  assign wd_expire = WD_EN && (state == MEM) && !mem_stage_ready && (wd_cnt == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= FETCH;
      cause_q       <= CAUSE_NONE;
      wd_cnt        <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (fetch_hs) begin
            if (fetch_fault) begin
              state   <= TRAP;
              cause_q <= CAUSE_FETCH_FAULT;
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          if (exec_hs) begin
            if (exec_exception) begin
              state   <= TRAP;
              cause_q <= CAUSE_EXCEPTION;
            end else if (mem_op) begin
              state  <= MEM;
              wd_cnt <= '0;
            end else if (wfi_op) begin
              state <= WFI;
            end else if (irq_pending) begin
              state   <= TRAP;
              cause_q <= CAUSE_IRQ;
            end else begin
              state <= FETCH;
            end
          end
        end
        MEM: begin
          if (mem_hs) begin
            if (mem_fault) begin
              state   <= TRAP;
              cause_q <= CAUSE_MEM_FAULT;
            end else if (irq_pending) begin
              state   <= TRAP;
              cause_q <= CAUSE_IRQ;
            end else begin
              state <= FETCH;
            end
          end else if (wd_expire) begin
            state         <= TRAP;
            cause_q       <= CAUSE_MEM_TIMEOUT;
            mem_timeout_q <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + TIMEOUT_W'(1);
          end
        end
        TRAP: begin
          state <= FETCH;
        end
        WFI: begin
          if (irq_pending) begin
            state   <= TRAP;
            cause_q <= CAUSE_IRQ;
          end
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

  core_ctrl_counters #(
    .CNT_W(CNT_W)
  ) u_counters (
    .clk          (clk),
    .rst_n        (rst_n),
    .retire       (retire),
    .cycle_count  (cycle_count),
    .instret_count(instret_count)
  );

endmodule

// File: tb/tb_core_seq_controller.sv
// Directed bench: a default-size sequencer plus a narrow instance (4-bit counters, watchdog of 4).
module tb_core_seq_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic fetch_stage_valid, fetch_stage_ready, fetch_fault;
  logic exec_stage_valid, exec_stage_ready, mem_op, wfi_op, exec_exception;
  logic mem_stage_valid, mem_stage_ready, mem_fault, irq_pending;
  logic reg_d_en, retire, trap_valid, mem_timeout;
  logic [2:0] trap_cause;
  logic [63:0] cycle_count, instret_count;

  // narrow instance
  logic s_fetch_stage_valid, s_fetch_stage_ready, s_fetch_fault;
  logic s_exec_stage_valid, s_exec_stage_ready, s_mem_op, s_wfi_op, s_exec_exception;
  logic s_mem_stage_valid, s_mem_stage_ready, s_mem_fault, s_irq_pending;
  logic s_reg_d_en, s_retire, s_trap_valid, s_mem_timeout;
  logic [2:0] s_trap_cause;
  logic [3:0] s_cycle_count, s_instret_count;

  int n_checks = 0;
  int n_pass   = 0;
  longint unsigned ncyc = 0;

  core_seq_controller u_dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_stage_valid(fetch_stage_valid), .fetch_stage_ready(fetch_stage_ready),
    .fetch_fault(fetch_fault),
    .exec_stage_valid(exec_stage_valid), .exec_stage_ready(exec_stage_ready),
    .mem_op(mem_op), .wfi_op(wfi_op), .exec_exception(exec_exception),
    .mem_stage_valid(mem_stage_valid), .mem_stage_ready(mem_stage_ready),
    .mem_fault(mem_fault), .irq_pending(irq_pending),
    .reg_d_en(reg_d_en), .retire(retire), .trap_valid(trap_valid),
    .trap_cause(trap_cause), .mem_timeout(mem_timeout),
    .cycle_count(cycle_count), .instret_count(instret_count)
  );

  core_seq_controller #(.CNT_W(4), .TIMEOUT_W(8), .MEM_TIMEOUT(4)) u_small (
    .clk(clk), .rst_n(rst_n),
    .fetch_stage_valid(s_fetch_stage_valid), .fetch_stage_ready(s_fetch_stage_ready),
    .fetch_fault(s_fetch_fault),
    .exec_stage_valid(s_exec_stage_valid), .exec_stage_ready(s_exec_stage_ready),
    .mem_op(s_mem_op), .wfi_op(s_wfi_op), .exec_exception(s_exec_exception),
    .mem_stage_valid(s_mem_stage_valid), .mem_stage_ready(s_mem_stage_ready),
    .mem_fault(s_mem_fault), .irq_pending(s_irq_pending),
    .reg_d_en(s_reg_d_en), .retire(s_retire), .trap_valid(s_trap_valid),
    .trap_cause(s_trap_cause), .mem_timeout(s_mem_timeout),
    .cycle_count(s_cycle_count), .instret_count(s_instret_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    ncyc++;
  endtask

  task automatic main_idle();
    fetch_stage_ready = 0; fetch_fault = 0; exec_stage_ready = 0; mem_op = 0;
    wfi_op = 0; exec_exception = 0; mem_stage_ready = 0; mem_fault = 0; irq_pending = 0;
  endtask

  // Issue one instruction's FETCH and EXEC handshakes, leaving the DUT in the state after EXEC.
  task automatic run_fetch_exec(input string tag, input logic exp_ret, input logic exp_wen);
    fetch_stage_ready = 1; exec_stage_ready = 1;
    #1 chk({tag, "_fetch_valid"}, fetch_stage_valid, 1);
    tick();
    #1 chk({tag, "_exec_valid"}, exec_stage_valid, 1);
    chk({tag, "_exec_retire"}, retire, exp_ret);
    chk({tag, "_exec_wen"}, reg_d_en, exp_wen);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    main_idle();
    s_fetch_stage_ready = 0; s_fetch_fault = 0; s_exec_stage_ready = 0; s_mem_op = 0;
    s_wfi_op = 0; s_exec_exception = 0; s_mem_stage_ready = 0; s_mem_fault = 0; s_irq_pending = 0;

    #1;
    chk("rst_fetch_valid", fetch_stage_valid, 0);
    chk("rst_trap_valid", trap_valid, 0);
    chk("rst_cycle", cycle_count, 0);
    chk("rst_mem_timeout", mem_timeout, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1; ncyc = 0;
    #1 chk("post_rst_fetch_valid", fetch_stage_valid, 1);
    chk("post_rst_cycle", cycle_count, 0);

    // counter wrap on the 4-bit instance
    repeat (15) tick();
    #1 chk("small_cycle_15", s_cycle_count, 15);
    chk("main_cycle_15", cycle_count, ncyc);
    tick();
    #1 chk("small_cycle_wrap", s_cycle_count, 0);
    chk("main_cycle_16", cycle_count, 16);

    // three ALU instructions at two cycles each
    for (int i = 0; i < 3; i++) run_fetch_exec("alu", 1, 1);
    #1 chk("alu_instret3", instret_count, 3);
    chk("alu_cycles", cycle_count, 22);
    chk("alu_back_fetch", fetch_stage_valid, 1);

    // load with ready on the fifth MEM cycle
    mem_op = 1;
    run_fetch_exec("ld", 0, 0);
    for (int k = 1; k <= 5; k++) begin
      mem_stage_ready = (k == 5);
      #1 chk("ld_mem_valid", mem_stage_valid, 1);
      chk("ld_wen", reg_d_en, k == 5);
      chk("ld_retire", retire, k == 5);
      tick();
    end
    main_idle();
    #1 chk("ld_instret", instret_count, 4);
    chk("ld_back_fetch", fetch_stage_valid, 1);

    // exception beats a simultaneous interrupt
    exec_exception = 1; irq_pending = 1;
    run_fetch_exec("exc", 0, 0);
    #1 chk("exc_trap_valid", trap_valid, 1);
    chk("exc_cause", trap_cause, 2);
    chk("exc_instret", instret_count, 4);
    main_idle();
    tick();
    #1 chk("exc_back_fetch", fetch_stage_valid, 1);

    // WFI retires, sleeps 10 cycles, wakes on interrupt
    wfi_op = 1;
    run_fetch_exec("wfi", 1, 0);
    main_idle();
    #1 chk("wfi_instret", instret_count, 5);
    for (int k = 0; k < 10; k++) begin
      chk("wfi_asleep", {fetch_stage_valid, exec_stage_valid, mem_stage_valid, trap_valid}, 0);
      tick();
    end
    irq_pending = 1;
    tick();
    #1 chk("wfi_trap_valid", trap_valid, 1);
    chk("wfi_cause", trap_cause, 7);
    irq_pending = 0;
    tick();
    #1 chk("wfi_back_fetch", fetch_stage_valid, 1);

    // ALU retire with interrupt pending: irq ignored at fetch, taken after retire
    irq_pending = 1;
    run_fetch_exec("irq", 1, 1);
    #1 chk("irq_trap_cause", trap_cause, 7);
    chk("irq_instret", instret_count, 6);
    main_idle();
    tick();

    // fetch fault
    fetch_stage_ready = 1; fetch_fault = 1;
    tick();
    #1 chk("ff_cause", trap_cause, 1);
    main_idle();
    tick();

    // mem fault: no write, no retire
    mem_op = 1;
    run_fetch_exec("mf", 0, 0);
    mem_stage_ready = 1; mem_fault = 1;
    #1 chk("mf_wen", reg_d_en, 0);
    chk("mf_retire", retire, 0);
    tick();
    #1 chk("mf_cause", trap_cause, 3);
    chk("mf_instret", instret_count, 6);
    main_idle();
    tick();

    // reset while in MEM
    mem_op = 1;
    run_fetch_exec("rm", 0, 0);
    main_idle();
    #1 chk("rm_in_mem", mem_stage_valid, 1);
    rst_n = 0;
    #1 chk("rm_mem_valid", mem_stage_valid, 0);
    chk("rm_cycle", cycle_count, 0);
    chk("rm_instret", instret_count, 0);
    chk("rm_fetch_valid", fetch_stage_valid, 0);
    @(posedge clk);
    #2 rst_n = 1; ncyc = 0;
    #1 chk("rm_release_fetch", fetch_stage_valid, 1);

    // narrow instance: ready on the expiry cycle wins
    s_fetch_stage_ready = 1; s_exec_stage_ready = 1; s_mem_op = 1;
    tick(); tick();
    for (int k = 1; k <= 4; k++) begin
      s_mem_stage_ready = (k == 4);
      #1 chk("wdr_mem_valid", s_mem_stage_valid, 1);
      chk("wdr_retire", s_retire, k == 4);
      tick();
    end
    s_mem_stage_ready = 0;
    #1 chk("wdr_no_trap", s_trap_valid, 0);
    chk("wdr_fetch", s_fetch_stage_valid, 1);
    chk("wdr_sticky_clear", s_mem_timeout, 0);

    // narrow instance: ready never comes
    tick(); tick();
    for (int k = 1; k <= 4; k++) begin
      #1 chk("wdt_mem_valid", s_mem_stage_valid, 1);
      chk("wdt_no_trap", s_trap_valid, 0);
      tick();
    end
    #1 chk("wdt_trap_valid", s_trap_valid, 1);
    chk("wdt_cause", s_trap_cause, 4);
    chk("wdt_sticky", s_mem_timeout, 1);
    chk("wdt_mem_drop", s_mem_stage_valid, 0);
    s_fetch_stage_ready = 0;
    tick();
    #1 chk("wdt_back_fetch", s_fetch_stage_valid, 1);
    chk("wdt_sticky_hold", s_mem_timeout, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
